// File: rtl/uart_apb_stream_bridge.sv
// UART APB stream bridge: configures a UART over APB, then polls STAT and
// moves bytes between a TX byte FIFO / RX holding register and the UART DATA
// register, one APB transfer per FSM state.
module uart_apb_stream_bridge #(
  parameter logic [19:0] BAUD_DIV   = 20'd867,
  parameter logic [3:0]  CTRL_VAL   = 4'h3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        presetn,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [11:0] m_paddr,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  input  logic        m_pslverr,
  input  logic [7:0]  tx_byte,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        init_done,
  output logic        bus_err
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_CTRL = 12'h000;
  localparam logic [ADDR_W-1:0] ADDR_STAT = 12'h004;
  localparam logic [ADDR_W-1:0] ADDR_DATA = 12'h008;
  localparam logic [ADDR_W-1:0] ADDR_BAUD = 12'h00C;

  typedef enum logic [2:0] {
    W_BAUD,
    W_CTRL,
    R_STAT,
    W_DATA,
    R_DATA
  } state_e;

  // PH_IDLE only exists right after reset, so the first SETUP lands on the
  // first clock edge once reset is released.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } phase_e;

  state_e state_q, state_d;
  phase_e phase_q, phase_d;

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_ready_q, tx_ready_d;

  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              rx_valid_q, rx_valid_d;
  logic              init_done_q, init_done_d;
  logic              bus_err_q, bus_err_d;

  logic              xfer_done;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [7:0]        fifo_head;
  logic              rx_load;
  logic              unused_prdata;

  assign xfer_done     = (phase_q == PH_ACCESS) && m_pready;
  assign fifo_push     = tx_valid && tx_ready_q;
  assign fifo_pop      = xfer_done && (state_q == W_DATA);
  assign rx_load       = xfer_done && (state_q == R_DATA);
  assign fifo_empty    = (cnt_q == '0);
  assign fifo_head     = mem_q[rd_ptr_q];
  assign unused_prdata = ^m_prdata[31:8];

  // FSM state register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= W_BAUD;
      phase_q <= PH_IDLE;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state: APB phase sequencing and register-access selection
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE:   phase_d = PH_SETUP;
      PH_SETUP:  phase_d = PH_ACCESS;
      PH_ACCESS: if (m_pready) phase_d = PH_SETUP;
      default:   phase_d = PH_IDLE;
    endcase
    if (xfer_done) begin
      case (state_q)
        W_BAUD: state_d = W_CTRL;
        W_CTRL: state_d = R_STAT;
        R_STAT: begin
          // RX drains first so the UART receive buffer cannot overrun.
          if (m_prdata[1] && !rx_valid_q) begin
            state_d = R_DATA;
          end else if (!m_prdata[0] && !fifo_empty) begin
            state_d = W_DATA;
          end else begin
            state_d = R_STAT;
          end
        end
        W_DATA:  state_d = R_STAT;
        R_DATA:  state_d = R_STAT;
        default: state_d = W_BAUD;
      endcase
    end
  end

  // Output decode: APB bus values for the upcoming cycle plus status flags
  always_comb begin
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = 1'b0;
    paddr_d   = '0;
    pwdata_d  = '0;
    if (phase_d != PH_IDLE) begin
      psel_d    = 1'b1;
      penable_d = (phase_d == PH_ACCESS);
      case (state_d)
        W_BAUD: begin
          pwrite_d = 1'b1;
          paddr_d  = ADDR_BAUD;
          pwdata_d = {12'h000, BAUD_DIV};
        end
        W_CTRL: begin
          pwrite_d = 1'b1;
          paddr_d  = ADDR_CTRL;
          pwdata_d = {28'h0000000, CTRL_VAL};
        end
        R_STAT: begin
          paddr_d = ADDR_STAT;
        end
        W_DATA: begin
          // Head is stable for the whole transfer: pop happens on completion
          // and pushes never land on the head slot while non-empty.
          pwrite_d = 1'b1;
          paddr_d  = ADDR_DATA;
          pwdata_d = {24'h000000, fifo_head};
        end
        R_DATA: begin
          paddr_d = ADDR_DATA;
        end
        default: begin
          paddr_d = '0;
        end
      endcase
    end
    init_done_d = init_done_q || (xfer_done && (state_q == W_CTRL));
    bus_err_d   = bus_err_q || (xfer_done && m_pslverr);
  end

  // TX FIFO next-state: pointer wrap is implicit in the power-of-two width
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (fifo_push) begin
      mem_d[wr_ptr_q] = tx_byte;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({fifo_push, fifo_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    tx_ready_d = (cnt_d < CNT_W'(FIFO_DEPTH));
  end

  // RX holding register next-state: load from DATA read, clear on handshake
  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    if (rx_load) begin
      rx_byte_d  = m_prdata[7:0];
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // Registered outputs and datapath state
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      tx_ready_q  <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      bus_err_q   <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      tx_ready_q  <= tx_ready_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      init_done_q <= init_done_d;
      bus_err_q   <= bus_err_d;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign m_psel    = psel_q;
  assign m_penable = penable_q;
  assign m_pwrite  = pwrite_q;
  assign m_paddr   = paddr_q;
  assign m_pwdata  = pwdata_q;
  assign tx_ready  = tx_ready_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign init_done = init_done_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_uart_apb_stream_bridge.sv
// Testbench for uart_apb_stream_bridge: acts as the APB UART slave and the
// byte-stream producer/consumer, with scoreboard queues of expected bytes.
module tb_uart_apb_stream_bridge;

  logic        pclk;
  logic        presetn;
  logic        m_psel, m_penable, m_pwrite;
  logic [11:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata;
  logic        m_pready, m_pslverr;
  logic [7:0]  tx_byte;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ready;
  logic        init_done, bus_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  uart_apb_stream_bridge #(
    .BAUD_DIV  (20'd867),
    .CTRL_VAL  (4'h3),
    .FIFO_DEPTH(4)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .m_psel   (m_psel),
    .m_penable(m_penable),
    .m_pwrite (m_pwrite),
    .m_paddr  (m_paddr),
    .m_pwdata (m_pwdata),
    .m_prdata (m_prdata),
    .m_pready (m_pready),
    .m_pslverr(m_pslverr),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .init_done(init_done),
    .bus_err  (bus_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Serve one APB transfer as the slave; reports what was seen and whether
  // the SETUP/ACCESS protocol and signal stability held.
  task automatic serve(input logic [31:0] rd, input int waits, input bit err,
                       output logic [11:0] a, output logic w, output logic [31:0] d,
                       output bit good, output bit rdy_seen);
    int n;
    good = 1'b1;
    rdy_seen = 1'b0;
    n = 0;
    while (m_psel !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    a = m_paddr;
    w = m_pwrite;
    d = m_pwdata;
    if (m_psel !== 1'b1) begin
      good = 1'b0;
      return;
    end
    if (m_penable === 1'b0) begin
      tick();
      if (m_psel !== 1'b1 || m_penable !== 1'b1) good = 1'b0;
    end
    if (m_paddr !== a || m_pwrite !== w || m_pwdata !== d) good = 1'b0;
    for (int i = 0; i < waits; i++) begin
      tick();
      rdy_seen = rdy_seen | (tx_ready === 1'b1);
      if (m_psel !== 1'b1 || m_penable !== 1'b1 || m_paddr !== a ||
          m_pwrite !== w || m_pwdata !== d) good = 1'b0;
    end
    m_pready  = 1'b1;
    m_prdata  = rd;
    m_pslverr = err;
    tick();
    m_pready  = 1'b0;
    m_prdata  = '0;
    m_pslverr = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, output bit acc);
    tx_byte  = b;
    tx_valid = 1'b1;
    acc      = (tx_ready === 1'b1);
    tick();
    tx_valid = 1'b0;
    tx_byte  = '0;
  endtask

  task automatic reset_and_init();
    logic [11:0] a;
    logic w;
    logic [31:0] d;
    bit g, r;
    presetn   = 1'b0;
    m_pready  = 1'b0;
    m_prdata  = '0;
    m_pslverr = 1'b0;
    tx_valid  = 1'b0;
    tx_byte   = '0;
    rx_ready  = 1'b0;
    tx_q.delete();
    rx_q.delete();
    tick();
    tick();
    @(negedge pclk);
    presetn = 1'b1;
    serve(32'h0, 0, 1'b0, a, w, d, g, r);
    serve(32'h0, 0, 1'b0, a, w, d, g, r);
  endtask

  task automatic test_reset();
    logic        es [1:6];
    logic        ee [1:6];
    logic [11:0] ea [1:6];
    logic        ew [1:6];
    logic [31:0] ed [1:6];
    logic        ei [1:6];
    presetn   = 1'b0;
    m_pready  = 1'b1;
    m_prdata  = '0;
    m_pslverr = 1'b0;
    tx_valid  = 1'b0;
    tx_byte   = '0;
    rx_ready  = 1'b0;
    tick();
    tick();
    total++;
    if ({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, tx_ready, rx_valid,
         rx_byte, init_done, bus_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs psel=%b pen=%b pwr=%b addr=%h wdata=%h txr=%b rxv=%b rxb=%h init=%b err=%b want all zero",
               m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, tx_ready, rx_valid,
               rx_byte, init_done, bus_err);
    end
    es = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ee = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ea = '{12'h00C, 12'h00C, 12'h000, 12'h000, 12'h004, 12'h004};
    ew = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ed = '{32'h363, 32'h363, 32'h3, 32'h3, 32'h0, 32'h0};
    ei = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    @(negedge pclk);
    presetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (m_psel !== es[k] || m_penable !== ee[k] || m_paddr !== ea[k] ||
          m_pwrite !== ew[k] || m_pwdata !== ed[k] || init_done !== ei[k]) begin
        bad++;
        $display("FAIL init_cycle%0d psel=%b pen=%b addr=%h wr=%b wdata=%h init=%b want %b %b %h %b %h %b",
                 k, m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, init_done,
                 es[k], ee[k], ea[k], ew[k], ed[k], ei[k]);
      end
      if (k == 1) begin
        total++;
        if (tx_ready !== 1'b1) begin
          bad++;
          $display("FAIL tx_ready_after_reset got=%b want=1", tx_ready);
        end
      end
    end
    m_pready = 1'b0;
  endtask

  task automatic test_tx_order();
    logic [11:0] ea [0:5];
    logic        ew [0:5];
    logic [7:0]  pb [0:1];
    logic [11:0] a;
    logic        w;
    logic [31:0] d;
    logic [7:0]  e;
    bit g, r, acc;
    reset_and_init();
    pb = '{8'h55, 8'hA3};
    foreach (pb[i]) begin
      push(pb[i], acc);
      total++;
      if (acc !== 1'b1) begin
        bad++;
        $display("FAIL order_push%0d accepted=%b want=1", i, acc);
      end else begin
        tx_q.push_back(pb[i]);
      end
    end
    ea = '{12'h004, 12'h008, 12'h004, 12'h008, 12'h004, 12'h004};
    ew = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      serve(32'h0, 0, 1'b0, a, w, d, g, r);
      total++;
      if (g !== 1'b1 || a !== ea[i] || w !== ew[i]) begin
        bad++;
        $display("FAIL order_xfer%0d good=%b addr=%h wr=%b want good=1 addr=%h wr=%b",
                 i, g, a, w, ea[i], ew[i]);
      end
      if (ew[i]) begin
        e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
        total++;
        if (d !== {24'h0, e}) begin
          bad++;
          $display("FAIL order_data%0d got=%h want=%h", i, d, {24'h0, e});
        end
      end
    end
    total++;
    if (tx_q.size() != 0) begin
      bad++;
      $display("FAIL order_leftover got=%0d want=0", tx_q.size());
    end
  endtask

  task automatic test_fifo_full();
    logic [11:0] ea [0:10];
    logic        ew [0:10];
    logic [31:0] rd [0:10];
    logic        exp_acc [0:4];
    logic [11:0] a;
    logic        w;
    logic [31:0] d;
    logic [7:0]  e;
    bit g, r, acc;
    reset_and_init();
    exp_acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i), acc);
      total++;
      if (acc !== exp_acc[i]) begin
        bad++;
        $display("FAIL full_push%0d accepted=%b want=%b", i, acc, exp_acc[i]);
      end
      if (acc) tx_q.push_back(8'h10 + 8'(i));
      if (i == 3) begin
        total++;
        if (tx_ready !== 1'b0) begin
          bad++;
          $display("FAIL full_tx_ready got=%b want=0", tx_ready);
        end
      end
    end
    ea = '{12'h004, 12'h004, 12'h008, 12'h004, 12'h008, 12'h004, 12'h008,
           12'h004, 12'h008, 12'h004, 12'h004};
    ew = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    rd = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 11; i++) begin
      serve(rd[i], 0, 1'b0, a, w, d, g, r);
      total++;
      if (g !== 1'b1 || a !== ea[i] || w !== ew[i]) begin
        bad++;
        $display("FAIL full_xfer%0d good=%b addr=%h wr=%b want good=1 addr=%h wr=%b",
                 i, g, a, w, ea[i], ew[i]);
      end
      if (ew[i]) begin
        e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
        total++;
        if (d !== {24'h0, e}) begin
          bad++;
          $display("FAIL full_data%0d got=%h want=%h", i, d, {24'h0, e});
        end
      end
    end
    total++;
    if (tx_q.size() != 0) begin
      bad++;
      $display("FAIL full_leftover got=%0d want=0", tx_q.size());
    end
  endtask

  task automatic test_rx_priority();
    logic [11:0] ea [0:7];
    logic        ew [0:7];
    logic [31:0] rd [0:7];
    logic [11:0] a;
    logic        w;
    logic [31:0] d;
    logic [7:0]  e;
    bit g, r, acc;
    reset_and_init();
    push(8'h77, acc);
    if (acc) tx_q.push_back(8'h77);
    ea = '{12'h004, 12'h008, 12'h004, 12'h008, 12'h004, 12'h004, 12'h004, 12'h008};
    ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rd = '{32'h3, 32'hABCD12C4, 32'h2, 32'h0, 32'h2, 32'h2, 32'h2, 32'h0000005A};
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        total++;
        e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        if (rx_valid !== 1'b1 || rx_byte !== e) begin
          bad++;
          $display("FAIL rx_hold valid=%b byte=%h want valid=1 byte=%h", rx_valid, rx_byte, e);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        total++;
        if (rx_valid !== 1'b0) begin
          bad++;
          $display("FAIL rx_clear valid=%b want=0", rx_valid);
        end
      end
      if (ea[i] == 12'h008 && !ew[i]) rx_q.push_back(rd[i][7:0]);
      serve(rd[i], 0, 1'b0, a, w, d, g, r);
      total++;
      if (g !== 1'b1 || a !== ea[i] || w !== ew[i]) begin
        bad++;
        $display("FAIL rx_xfer%0d good=%b addr=%h wr=%b want good=1 addr=%h wr=%b",
                 i, g, a, w, ea[i], ew[i]);
      end
      if (ew[i]) begin
        e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
        total++;
        if (d !== {24'h0, e}) begin
          bad++;
          $display("FAIL rx_txdata%0d got=%h want=%h", i, d, {24'h0, e});
        end
      end
    end
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    total++;
    if (rx_valid !== 1'b1 || rx_byte !== e) begin
      bad++;
      $display("FAIL rx_second valid=%b byte=%h want valid=1 byte=%h", rx_valid, rx_byte, e);
    end
  endtask

  task automatic test_wait_err();
    logic [11:0] ea [0:6];
    logic        ew [0:6];
    logic [11:0] a;
    logic        w;
    logic [31:0] d;
    logic [7:0]  e;
    bit g, r, acc;
    reset_and_init();
    for (int i = 0; i < 4; i++) begin
      push(8'h3C + 8'(i), acc);
      if (acc) tx_q.push_back(8'h3C + 8'(i));
    end
    total++;
    if (tx_ready !== 1'b0 || bus_err !== 1'b0) begin
      bad++;
      $display("FAIL werr_pre txr=%b err=%b want txr=0 err=0", tx_ready, bus_err);
    end
    serve(32'h0, 0, 1'b0, a, w, d, g, r);
    serve(32'h0, 3, 1'b1, a, w, d, g, r);
    e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
    total++;
    if (g !== 1'b1 || a !== 12'h008 || w !== 1'b1 || d !== {24'h0, e}) begin
      bad++;
      $display("FAIL werr_stall good=%b addr=%h wr=%b data=%h want good=1 addr=008 wr=1 data=%h",
               g, a, w, d, {24'h0, e});
    end
    total++;
    if (r !== 1'b0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL werr_pop_timing ready_during_wait=%b txr_after=%b want 0 and 1", r, tx_ready);
    end
    total++;
    if (bus_err !== 1'b1) begin
      bad++;
      $display("FAIL werr_set got=%b want=1", bus_err);
    end
    ea = '{12'h004, 12'h008, 12'h004, 12'h008, 12'h004, 12'h008, 12'h004};
    ew = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      serve(32'h0, 0, 1'b0, a, w, d, g, r);
      total++;
      if (g !== 1'b1 || a !== ea[i] || w !== ew[i]) begin
        bad++;
        $display("FAIL werr_xfer%0d good=%b addr=%h wr=%b want good=1 addr=%h wr=%b",
                 i, g, a, w, ea[i], ew[i]);
      end
      if (ew[i]) begin
        e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
        total++;
        if (d !== {24'h0, e}) begin
          bad++;
          $display("FAIL werr_data%0d got=%h want=%h", i, d, {24'h0, e});
        end
      end
    end
    total++;
    if (bus_err !== 1'b1) begin
      bad++;
      $display("FAIL werr_sticky got=%b want=1", bus_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] a;
    logic        w;
    logic [31:0] d;
    bit g, r, acc;
    reset_and_init();
    push(8'h11, acc);
    push(8'h22, acc);
    serve(32'h0, 0, 1'b0, a, w, d, g, r);
    tick();
    total++;
    if (m_psel !== 1'b1 || m_penable !== 1'b1 || m_paddr !== 12'h008 || m_pwrite !== 1'b1) begin
      bad++;
      $display("FAIL mid_access psel=%b pen=%b addr=%h wr=%b want 1 1 008 1",
               m_psel, m_penable, m_paddr, m_pwrite);
    end
    #2;
    presetn = 1'b0;
    #1;
    total++;
    if (m_psel !== 1'b0 || m_penable !== 1'b0 || m_paddr !== 12'h000 ||
        tx_ready !== 1'b0 || init_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_async psel=%b pen=%b addr=%h txr=%b init=%b want all zero",
               m_psel, m_penable, m_paddr, tx_ready, init_done);
    end
    @(negedge pclk);
    presetn = 1'b1;
    serve(32'h0, 0, 1'b0, a, w, d, g, r);
    total++;
    if (g !== 1'b1 || a !== 12'h00C || w !== 1'b1 || d !== 32'h363) begin
      bad++;
      $display("FAIL mid_baud good=%b addr=%h wr=%b data=%h want 1 00c 1 00000363", g, a, w, d);
    end
    serve(32'h0, 0, 1'b0, a, w, d, g, r);
    total++;
    if (g !== 1'b1 || a !== 12'h000 || w !== 1'b1 || d !== 32'h3) begin
      bad++;
      $display("FAIL mid_ctrl good=%b addr=%h wr=%b data=%h want 1 000 1 00000003", g, a, w, d);
    end
    serve(32'h0, 0, 1'b0, a, w, d, g, r);
    serve(32'h0, 0, 1'b0, a, w, d, g, r);
    total++;
    if (g !== 1'b1 || a !== 12'h004 || w !== 1'b0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_empty good=%b addr=%h wr=%b txr=%b want 1 004 0 1", g, a, w, tx_ready);
    end
  endtask

  initial begin
    presetn   = 1'b0;
    m_prdata  = '0;
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
    tx_byte   = '0;
    tx_valid  = 1'b0;
    rx_ready  = 1'b0;
    test_reset();
    test_tx_order();
    test_fifo_full();
    test_rx_priority();
    test_wait_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_apb_stream_bridge.md
UART_APB_STREAM_BRIDGE -- requirements
Module: uart_apb_stream_bridge

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: pclk and presetn.
REQ-002 SHALL have parameter BAUD_DIV, default 20'd867: value written to the UART BAUD register at init.
REQ-003 SHALL have parameter CTRL_VAL, default 4'h3: value written to the UART CTRL register at init (TX enable, RX enable, interrupts off).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: TX byte FIFO depth, a power of two from 2 to 16.
REQ-005 SHALL have the following ports:
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- m_psel  out  1  APB select
- m_penable  out  1  APB enable
- m_pwrite  out  1  APB write
- m_paddr  out  12  APB address
- m_pwdata  out  32  APB write data
- m_prdata  in  32  APB read data
- m_pready  in  1  APB ready
- m_pslverr  in  1  APB error
- tx_byte  in  8  byte to transmit
- tx_valid  in  1  tx_byte valid
- tx_ready  out  1  FIFO can accept
- rx_byte  out  8  received byte
- rx_valid  out  1  rx_byte valid
- rx_ready  in  1  consumer accepts rx_byte
- init_done  out  1  UART configured
- bus_err  out  1  sticky, set on m_pslverr

Function
REQ-006 SHALL use UART register offsets CTRL 0x000, STAT 0x004, DATA 0x008, BAUD 0x00C; STAT bit0 = tx_buf_full, bit1 = rx_buf_full.
REQ-007 SHALL run every APB transfer as SETUP (psel=1, penable=0) for exactly 1 cycle, then ACCESS (psel=1, penable=1) until m_pready=1.
REQ-008 SHALL hold paddr, pwrite and pwdata stable across SETUP and ACCESS, and SHALL drive psel=0, penable=0, paddr=0, pwdata=0 between transfers.
REQ-009 Main FSM states SHALL be: W_BAUD, W_CTRL, R_STAT, W_DATA, R_DATA; each state issues one APB transfer.
REQ-010 After reset the FSM SHALL run W_BAUD (pwdata={12'h0,BAUD_DIV}), then W_CTRL (pwdata={28'h0,CTRL_VAL}), then R_STAT.
REQ-011 init_done SHALL assert in the cycle after W_CTRL completes and SHALL stay high until reset.
REQ-012 On R_STAT completion, SHALL sample m_prdata[1:0] and go to R_DATA if bit1=1 and rx_valid=0; else W_DATA if bit0=0 and FIFO not empty; else R_STAT again.
REQ-013 RX SHALL have priority over TX when both are eligible.
REQ-014 W_DATA SHALL drive pwdata={24'h0, FIFO head}, pop the FIFO on ACCESS completion, then return to R_STAT.
REQ-015 R_DATA SHALL load rx_byte=m_prdata[7:0], set rx_valid=1 on ACCESS completion, then return to R_STAT.
REQ-016 rx_valid SHALL clear in the cycle after rx_valid & rx_ready, and rx_byte SHALL hold while rx_valid=1.
REQ-017 The FIFO SHALL push on tx_valid & tx_ready; tx_ready SHALL be count<FIFO_DEPTH; push and pop in the same cycle SHALL leave the count unchanged.
REQ-018 When full, tx_ready=0 and tx_byte SHALL be ignored.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-020 Bytes SHALL be written to DATA in push order, with no loss or duplication.
REQ-021 bus_err SHALL set when m_pslverr=1 on any completing ACCESS and SHALL clear only on reset.
REQ-022 The FSM SHALL continue normally after an error; on a failed W_DATA the FIFO entry is still popped.

Reset
REQ-023 With presetn=0, outputs SHALL be: m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0, tx_ready=0, rx_valid=0, rx_byte=0, init_done=0, bus_err=0.
REQ-024 With presetn=0, the FIFO SHALL be empty and the FSM SHALL be in W_BAUD with no transfer in progress.
REQ-025 The first SETUP SHALL occur on the first pclk edge after presetn deasserts.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer immediately and discard FIFO contents and any pending rx_byte.
REQ-027 tx_ready SHALL go to 1 on the first cycle after reset deasserts.

Verification
REQ-028 Release reset with m_pready=1 -> writes 0x00C←0x00000363 then 0x000←0x00000003, 2 cycles each; init_done=1 at cycle 5; then reads of 0x004 begin.
REQ-029 Push 0x55, 0xA3 with STAT returning 0x0 -> writes 0x008←0x55, then a STAT read, then 0x008←0xA3; FIFO empty afterwards.
REQ-030 Push 5 bytes back-to-back at FIFO_DEPTH=4 with STAT=0x1 -> tx_ready=0 after the 4th push and the 5th byte is not accepted; STAT=0x0 then drains the 4 bytes in order.
REQ-031 STAT=0x3, FIFO non-empty, rx_valid=0 -> R_DATA runs before W_DATA; rx_byte equals m_prdata[7:0]; with rx_ready=0 later STAT=0x2 polls issue no further DATA reads.
REQ-032 m_pready held 0 for 3 cycles in W_DATA ACCESS -> address and data stay stable and the pop occurs only on the ready cycle; m_pslverr=1 on a completion -> bus_err=1 and stays 1.
REQ-033 Assert presetn=0 during W_DATA ACCESS -> psel/penable drop asynchronously; after release the W_BAUD sequence restarts with an empty FIFO.
